// File: rtl/rz_scan_ctrl_if.sv
// rtl/rz_scan_ctrl_if.sv - output word stream between scan sequencer and frame formatter
//
// Signals:
//   out_data   16  stream word (header or RAM data)
//   out_ch      3  channel number 1..6 of the current word
//   out_hdr     1  1 = header word
//   out_valid   1  word valid, held stable until accepted
//   out_ready   1  downstream accept
// Modports: master = sequencer side, slave = formatter side.
interface rz_scan_ctrl_if;
    logic [15:0] out_data;
    logic [2:0]  out_ch;
    logic        out_hdr;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output out_data,
        output out_ch,
        output out_hdr,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_ch,
        input  out_hdr,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/rz_scan_ctrl.sv
// rtl/rz_scan_ctrl.sv - read-side scan sequencer for the six-channel ARINC429 receive RAMs
//
// Walks every enabled channel on a start pulse, reading words 0..WORDS-1 through
// one shared RAM address, and emits a header word plus the data words per channel.
//
// Ports:
//   clock     in   system clock, shared with the RAM read ports
//   reset     in   asynchronous active-low reset
//   start     in   one-cycle scan request
//   ch_mask   in   channel enables, latched on an accepted start
//   q_in      in   concatenated RAM outputs, channel 1 in [15:0]
//   rd_addr   out  shared RAM read address
//   os        --   output stream (rz_scan_ctrl_if.master)
//   busy      out  scan in progress
//   done      out  one-cycle pulse at end of scan
//   overrun   out  sticky, start seen while busy
module rz_scan_ctrl #(
    parameter int          N_CH    = 6,
    parameter int          WORDS   = 16,
    parameter int          RD_LAT  = 1,
    parameter logic [7:0]  HDR_TAG = 8'hA5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [5:0]           ch_mask,
    input  logic [95:0]          q_in,
    output logic [4:0]           rd_addr,
    rz_scan_ctrl_if.master       os,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SEL  = 3'd1,
        S_HDR  = 3'd2,
        S_ADDR = 3'd3,
        S_WAIT = 3'd4,
        S_PRES = 3'd5,
        S_FIN  = 3'd6
    } state_t;

    localparam logic [4:0] LAST_WORD = 5'(WORDS - 1);
    localparam logic [1:0] LAT_INIT  = 2'(RD_LAT);

    state_t      state, state_nxt;
    logic [5:0]  mask;
    logic [2:0]  ch;
    logic [4:0]  idx;
    logic [1:0]  cnt;
    logic [15:0] data_r;
    logic [2:0]  ch_out;
    logic        hdr_r;

    logic        sel_found;
    logic [2:0]  sel_ch;
    logic [15:0] q_sel;
    logic        xfer;

    // Lowest enabled channel at or above the pointer; bits >= N_CH never match.
    always_comb begin
        sel_found = 1'b0;
        sel_ch    = ch;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (i >= int'(ch) && mask[i]) begin
                sel_found = 1'b1;
                sel_ch    = 3'(i);
            end
        end
    end

    always_comb begin
        q_sel = '0;
        for (int i = 0; i < 6; i++) begin
            if (ch == 3'(i)) begin
                q_sel = q_in[i*16 +: 16];
            end
        end
    end

    assign xfer = os.out_valid && os.out_ready;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_SEL;
            S_SEL:  state_nxt = sel_found ? S_HDR : S_FIN;
            S_HDR:  if (xfer) state_nxt = S_ADDR;
            S_ADDR: state_nxt = S_WAIT;
            // Capture happens as the countdown reaches zero, so the data word
            // is valid RD_LAT+1 cycles after the header transfer.
            S_WAIT: if (cnt == 2'd1) state_nxt = S_PRES;
            S_PRES: if (xfer) state_nxt = (idx < LAST_WORD) ? S_ADDR : S_SEL;
            S_FIN:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        os.out_valid = (state == S_HDR) || (state == S_PRES);
        busy         = (state != S_IDLE);
        done         = (state == S_FIN);
    end

    assign os.out_data = data_r;
    assign os.out_ch   = ch_out;
    assign os.out_hdr  = hdr_r;

    // Datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mask    <= '0;
            ch      <= '0;
            idx     <= '0;
            cnt     <= '0;
            rd_addr <= '0;
            data_r  <= '0;
            ch_out  <= '0;
            hdr_r   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mask    <= ch_mask;
                        ch      <= '0;
                        overrun <= 1'b0;
                    end
                end
                S_SEL: begin
                    // Header word is loaded here so it is stable for the whole HDR state.
                    if (sel_found) begin
                        ch     <= sel_ch;
                        data_r <= {HDR_TAG, 5'b0, sel_ch + 3'd1};
                        ch_out <= sel_ch + 3'd1;
                        hdr_r  <= 1'b1;
                    end
                end
                S_HDR: begin
                    if (xfer) idx <= '0;
                end
                S_ADDR: begin
                    rd_addr <= idx;
                    cnt     <= LAT_INIT;
                end
                S_WAIT: begin
                    cnt <= cnt - 2'd1;
                    if (cnt == 2'd1) begin
                        data_r <= q_sel;
                        hdr_r  <= 1'b0;
                    end
                end
                S_PRES: begin
                    if (xfer) begin
                        if (idx < LAST_WORD) idx <= idx + 5'd1;
                        else                 ch  <= ch + 3'd1;
                    end
                end
                S_FIN: begin
                    rd_addr <= '0;
                end
                default: ;
            endcase
            // Any start outside IDLE (including the done cycle) is dropped and flagged.
            if (start && state != S_IDLE) overrun <= 1'b1;
        end
    end

endmodule

// File: doc/rz_scan_ctrl.md
Name: rz_scan_ctrl

Overview:
Read-side sequencer for the six-channel ARINC429 receive block. On a start pulse it walks every enabled channel and reads words 0..WORDS-1 from each channel's RAM. It drives one shared read address to all six channel RAMs and selects the matching q. Each channel's data is emitted as one header word followed by its data words, on a valid/ready stream toward the frame formatter.

Parameters:
N_CH, 6, number of channel RAMs scanned (1..6)
WORDS, 16, words read per channel, addresses 0..WORDS-1 (1..32)
RD_LAT, 1, clock cycles from rd_addr change to valid q (1..3)
HDR_TAG, 8'hA5, upper byte of per-channel header word

Ports:
clock  in  1  system clock (same clock as channel RAM read port)
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle scan request (typically the sec tick)
ch_mask  in  6  bit i=1 enables channel i+1; sampled on accepted start
q_in  in  96  concatenated RAM outputs, channel 1 in [15:0] ... channel 6 in [95:80]
rd_addr  out  5  shared read address to all channel RAMs
out_data  out  16  stream word
out_ch  out  3  channel number 1..6 of current word
out_hdr  out  1  1 = header word
out_valid  out  1  out_data/out_ch/out_hdr valid
out_ready  in  1  downstream accept
busy  out  1  scan in progress
done  out  1  one-cycle pulse after last word of scan accepted
overrun  out  1  sticky: start arrived while busy

Behaviour:
- Reset (reset=0, async): state IDLE; rd_addr=0, out_data=0, out_ch=0, out_hdr=0, out_valid=0, busy=0, done=0, overrun=0; latched mask=0.
- Transfer occurs on a clock edge with out_valid=1 and out_ready=1. While out_valid=1, out_data/out_ch/out_hdr are held stable until transfer.
- States: IDLE, SEL, HDR, ADDR, WAIT, PRES, FIN.
- IDLE: on start=1: latch mask=ch_mask, clear overrun, busy<=1, ch ptr<=0, go SEL.
- SEL: search from ch ptr upward for the first latched-mask bit set (ch < N_CH).
  - Found: go HDR.
  - None: go FIN.
- HDR: out_data={HDR_TAG, 5'b0, ch[2:0]+1}, out_hdr=1, out_ch=ch+1, out_valid=1. Hold until transfer, then word index=0 and go ADDR.
- ADDR: rd_addr<=word index, counter<=RD_LAT, go WAIT.
- WAIT: decrement the counter each cycle. When it reaches 0, capture q_in slice[ch] into out_data with out_hdr=0 and out_valid=1, go PRES.
- PRES: hold until transfer, then:
  - word index<WORDS-1: increment it, go ADDR.
  - Otherwise: ch ptr<=ch+1, go SEL.
- FIN: busy<=0, done=1 for exactly one cycle, go IDLE. An empty mask (all zero) reaches FIN directly: done rises 2 cycles after start, and no words are emitted.
- Timing: the first data word is valid at the earliest RD_LAT+1 cycles after header transfer. Each subsequent data word takes at least RD_LAT+2 cycles per word when out_ready=1.
- rd_addr holds its last value between reads and returns to 0 in IDLE.
- start while busy (any state other than IDLE): ignored; overrun<=1 (sticky until next accepted start or reset). start in the same cycle as done is also ignored and sets overrun.
- ch_mask changes during a scan have no effect; only the latched mask is used.
- Mask bits at or above N_CH are ignored.
- out_ready is ignored while out_valid=0.
- Reset asserted mid-scan: immediate return to reset values, no done pulse. The partially emitted scan is abandoned.
- Total transfers per scan = popcount(mask)*(WORDS+1).

Test Plan:
- Mask 6'b000001, WORDS=16, RAM1 word k = 16'h1000+k, out_ready=1 -> header 16'hA501, then 16'h1000..16'h100F in order, out_ch=1; done pulses once; 17 transfers total.
- Mask 6'b100100, RAM3 word k=16'h3000+k, RAM6 word k=16'h6000+k -> expected output:
  - header 16'hA503, then 16'h3000..300F;
  - header 16'hA506, then 16'h6000..600F;
  - 34 transfers; channels 1,2,4,5 are never selected.
- Backpressure: mask 6'b000010, out_ready toggling 1/0 every cycle, plus a 10-cycle ready=0 stall on word 5 -> out_data=16'h2005 held stable throughout the stall; no word lost or duplicated; 17 transfers.
- Mask 6'b000000 -> no out_valid; busy high 2 cycles; done 2 cycles after start.
- start pulsed again mid-scan -> overrun=1 and stays 1; the scan completes unchanged. The next start in IDLE clears overrun.
- reset driven low while PRES on channel 4 word 7 -> all outputs 0 asynchronously. After release, a new start with mask 6'b111111 emits 102 transfers from channel 1 word 0.
